// File: rtl/riscv8_pkg.sv
// Shared types and constants for the 8-bit five-stage pipeline.
// Used by fetch_stage and, when FETCH_JUMP_PREDECODE_EN is defined, jump_predecode.
package riscv8_pkg;

    localparam int unsigned PC_W    = 8;
    localparam int unsigned INSTR_W = 8;
    localparam int unsigned IMM_W   = 6;

    typedef enum logic [1:0] {
        OPC_ALU = 2'b00,
        OPC_LD  = 2'b01,
        OPC_BR  = 2'b10,
        OPC_J   = 2'b11
    } opcode_t;

    typedef struct packed {
        logic               valid;
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
    } ifid_t;

endpackage

// File: rtl/jump_predecode.sv
// Combinational decode of the j opcode and its pc-relative target.
// Compiled only when FETCH_JUMP_PREDECODE_EN is defined.
`ifdef FETCH_JUMP_PREDECODE_EN
module jump_predecode #(
    parameter int unsigned PC_W    = 8,
    parameter int unsigned INSTR_W = 8
) (
    input  logic [INSTR_W-1:0] instr,
    input  logic [PC_W-1:0]    pc,
    output logic               is_jump,
    output logic [PC_W-1:0]    target
);
    import riscv8_pkg::*;

    logic [PC_W-1:0] offset;

    always_comb begin
        is_jump = (instr[7:6] == OPC_J);
        offset  = {{(PC_W-IMM_W){instr[IMM_W-1]}}, instr[IMM_W-1:0]};
        // Truncation to PC_W gives modulo-2^PC_W wrap for both directions.
        target  = pc + PC_W'(1) + offset;
    end

endmodule
`endif

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, IF/ID register, stall/redirect/halt handling.
// Define FETCH_JUMP_PREDECODE_EN to resolve j in fetch via jump_predecode.
module fetch_stage #(
    parameter int unsigned     PC_W        = 8,
    parameter int unsigned     INSTR_W     = 8,
    parameter logic [PC_W-1:0] FETCH_LIMIT = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall_i,
    input  logic               redirect_valid_i,
    input  logic [PC_W-1:0]    redirect_pc_i,
    output logic [PC_W-1:0]    imem_pc_o,
    input  logic [INSTR_W-1:0] imem_instr_i,
    output logic               ifid_valid_o,
    output logic [INSTR_W-1:0] ifid_instr_o,
    output logic [PC_W-1:0]    ifid_pc_o,
    output logic               halted_o
);
    import riscv8_pkg::*;

    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] next_pc;
    logic            halted;

`ifdef FETCH_JUMP_PREDECODE_EN
    logic            is_jump;
    logic [PC_W-1:0] jump_target;

    jump_predecode #(
        .PC_W    (PC_W),
        .INSTR_W (INSTR_W)
    ) u_predecode (
        .instr   (imem_instr_i),
        .pc      (pc),
        .is_jump (is_jump),
        .target  (jump_target)
    );

    always_comb begin
        next_pc = is_jump ? jump_target : pc + PC_W'(1);
    end
`else
    always_comb begin
        next_pc = pc + PC_W'(1);
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc           <= '0;
            halted       <= 1'b0;
            ifid_valid_o <= 1'b0;
            ifid_instr_o <= '0;
            ifid_pc_o    <= '0;
        end else if (redirect_valid_i) begin
            // Redirect beats stall so a flush is never lost behind a hazard hold.
            pc           <= redirect_pc_i;
            ifid_valid_o <= 1'b0;
            halted       <= (redirect_pc_i >= FETCH_LIMIT);
        end else if (stall_i) begin
            pc           <= pc;
        end else if (halted) begin
            ifid_valid_o <= 1'b0;
        end else begin
            ifid_valid_o <= 1'b1;
            ifid_instr_o <= imem_instr_i;
            ifid_pc_o    <= pc;
            pc           <= next_pc;
            halted       <= (next_pc >= FETCH_LIMIT);
        end
    end

    assign imem_pc_o = pc;
    assign halted_o  = halted;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage; follows FETCH_JUMP_PREDECODE_EN if defined.
// Directed scenarios use fixed expectations; the random run uses a behavioural model.
module tb_fetch_stage;

`ifdef FETCH_JUMP_PREDECODE_EN
    localparam bit PREDECODE = 1'b1;
`else
    localparam bit PREDECODE = 1'b0;
`endif
    localparam int LIMIT = 6;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       stall = 1'b0;
    logic       redirect_valid = 1'b0;
    logic [7:0] redirect_pc = 8'h00;
    logic [7:0] imem_pc;
    logic [7:0] imem_instr;
    logic       ifid_valid;
    logic [7:0] ifid_instr;
    logic [7:0] ifid_pc;
    logic       halted;

    logic [7:0] mem [256];
    int checks = 0;
    int failures = 0;

    // behavioural model state
    int m_pc, m_ifpc, m_instr;
    bit m_valid, m_halted;

    always #5 clk = ~clk;

    assign imem_instr = mem[imem_pc];

    fetch_stage #(
        .PC_W        (8),
        .INSTR_W     (8),
        .FETCH_LIMIT (8'd6)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .stall_i          (stall),
        .redirect_valid_i (redirect_valid),
        .redirect_pc_i    (redirect_pc),
        .imem_pc_o        (imem_pc),
        .imem_instr_i     (imem_instr),
        .ifid_valid_o     (ifid_valid),
        .ifid_instr_o     (ifid_instr),
        .ifid_pc_o        (ifid_pc),
        .halted_o         (halted)
    );

    // Apply the fetch rules to the model for the inputs presented at this edge.
    task automatic model_edge();
        int ins, off;
        if (!rst) begin
            m_pc = 0; m_halted = 0; m_valid = 0; m_instr = 0; m_ifpc = 0;
        end else if (redirect_valid) begin
            m_pc = redirect_pc; m_valid = 0; m_halted = (redirect_pc >= LIMIT);
        end else if (stall) begin
            m_pc = m_pc;
        end else if (m_halted) begin
            m_valid = 0;
        end else begin
            ins = mem[m_pc];
            m_valid = 1; m_instr = ins; m_ifpc = m_pc;
            if (PREDECODE && (ins / 64) == 3) begin
                off = ins % 64;
                if (off >= 32) off = off - 64;
                m_pc = (m_pc + 1 + off + 256) % 256;
            end else begin
                m_pc = (m_pc + 1) % 256;
            end
            m_halted = (m_pc >= LIMIT);
        end
    endtask

    task automatic clk_edge();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 8'h00;
        clk_edge();
        clk_edge();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0; stall = 1'b0; redirect_valid = 1'b0;
        clk_edge();
        clk_edge();
        checks++; if (imem_pc !== 8'h00) begin failures++; $display("FAIL reset_imem_pc got=%0h exp=0", imem_pc); end
        checks++; if (ifid_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0h exp=0", ifid_valid); end
        checks++; if (ifid_instr !== 8'h00) begin failures++; $display("FAIL reset_instr got=%0h exp=0", ifid_instr); end
        checks++; if (ifid_pc !== 8'h00) begin failures++; $display("FAIL reset_pc got=%0h exp=0", ifid_pc); end
        checks++; if (halted !== 1'b0) begin failures++; $display("FAIL reset_halted got=%0h exp=0", halted); end
        rst = 1'b1;
    endtask

    task automatic test_sequence();
        logic [7:0] exp_pc [6];
        logic [7:0] exp_in [6];
        int n;
        if (PREDECODE) begin
            exp_pc = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd5, 8'd0};
            exp_in = '{8'h23, 8'h61, 8'h1A, 8'hC1, 8'h3C, 8'h00};
            n = 5;
        end else begin
            exp_pc = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5};
            exp_in = '{8'h23, 8'h61, 8'h1A, 8'hC1, 8'h5B, 8'h3C};
            n = 6;
        end
        do_reset();
        for (int i = 0; i < n; i++) begin
            clk_edge();
            checks++; if (ifid_valid !== 1'b1) begin failures++; $display("FAIL seq_valid[%0d] got=%0h exp=1", i, ifid_valid); end
            checks++; if (ifid_pc !== exp_pc[i]) begin failures++; $display("FAIL seq_pc[%0d] got=%0h exp=%0h", i, ifid_pc, exp_pc[i]); end
            checks++; if (ifid_instr !== exp_in[i]) begin failures++; $display("FAIL seq_instr[%0d] got=%0h exp=%0h", i, ifid_instr, exp_in[i]); end
            checks++; if (halted !== (i == n - 1)) begin failures++; $display("FAIL seq_halted[%0d] got=%0h exp=%0h", i, halted, (i == n - 1)); end
        end
        for (int i = 0; i < 3; i++) begin
            clk_edge();
            checks++; if (ifid_valid !== 1'b0) begin failures++; $display("FAIL halt_valid[%0d] got=%0h exp=0", i, ifid_valid); end
            checks++; if (halted !== 1'b1) begin failures++; $display("FAIL halt_hold[%0d] got=%0h exp=1", i, halted); end
            checks++; if (imem_pc !== 8'd6) begin failures++; $display("FAIL halt_pc[%0d] got=%0h exp=6", i, imem_pc); end
        end
    endtask

    task automatic test_stall();
        do_reset();
        clk_edge();
        clk_edge();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            clk_edge();
            checks++; if (ifid_valid !== 1'b1 || ifid_instr !== 8'h61 || ifid_pc !== 8'd1)
                begin failures++; $display("FAIL stall_hold[%0d] got=%0h/%0h/%0h exp=1/61/1", i, ifid_valid, ifid_instr, ifid_pc); end
            checks++; if (imem_pc !== 8'd2) begin failures++; $display("FAIL stall_imem_pc[%0d] got=%0h exp=2", i, imem_pc); end
        end
        stall = 1'b0;
        clk_edge();
        checks++; if (ifid_valid !== 1'b1 || ifid_instr !== 8'h1A || ifid_pc !== 8'd2)
            begin failures++; $display("FAIL stall_release got=%0h/%0h/%0h exp=1/1a/2", ifid_valid, ifid_instr, ifid_pc); end
    endtask

    task automatic test_redirect_stall();
        do_reset();
        clk_edge();
        clk_edge();
        clk_edge();
        checks++; if (ifid_pc !== 8'd2) begin failures++; $display("FAIL redir_setup_pc got=%0h exp=2", ifid_pc); end
        stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 8'd4;
        clk_edge();
        checks++; if (ifid_valid !== 1'b0) begin failures++; $display("FAIL redir_bubble got=%0h exp=0", ifid_valid); end
        checks++; if (imem_pc !== 8'd4) begin failures++; $display("FAIL redir_imem_pc got=%0h exp=4", imem_pc); end
        stall = 1'b0; redirect_valid = 1'b0;
        clk_edge();
        checks++; if (ifid_valid !== 1'b1 || ifid_instr !== 8'h5B || ifid_pc !== 8'd4)
            begin failures++; $display("FAIL redir_target got=%0h/%0h/%0h exp=1/5b/4", ifid_valid, ifid_instr, ifid_pc); end
    endtask

    task automatic test_redirect_halted();
        int budget;
        do_reset();
        budget = 0;
        while (halted !== 1'b1 && budget < 20) begin
            clk_edge();
            budget++;
        end
        checks++; if (halted !== 1'b1) begin failures++; $display("FAIL rh_reach_halt got=%0h exp=1", halted); end
        redirect_valid = 1'b1; redirect_pc = 8'h00;
        clk_edge();
        redirect_valid = 1'b0;
        checks++; if (halted !== 1'b0) begin failures++; $display("FAIL rh_unhalt got=%0h exp=0", halted); end
        checks++; if (ifid_valid !== 1'b0) begin failures++; $display("FAIL rh_bubble got=%0h exp=0", ifid_valid); end
        clk_edge();
        checks++; if (ifid_valid !== 1'b1 || ifid_instr !== 8'h23 || ifid_pc !== 8'd0)
            begin failures++; $display("FAIL rh_restart got=%0h/%0h/%0h exp=1/23/0", ifid_valid, ifid_instr, ifid_pc); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 4; i++) clk_edge();
        checks++; if (ifid_pc !== 8'd3) begin failures++; $display("FAIL rm_setup_pc got=%0h exp=3", ifid_pc); end
        rst = 1'b0;
        clk_edge();
        checks++; if (ifid_valid !== 1'b0 || ifid_instr !== 8'h00 || ifid_pc !== 8'h00 || halted !== 1'b0 || imem_pc !== 8'h00)
            begin failures++; $display("FAIL rm_zero got=%0h/%0h/%0h/%0h/%0h exp=0/0/0/0/0", ifid_valid, ifid_instr, ifid_pc, halted, imem_pc); end
        rst = 1'b1;
        clk_edge();
        checks++; if (ifid_valid !== 1'b1 || ifid_instr !== 8'h23 || ifid_pc !== 8'd0)
            begin failures++; $display("FAIL rm_restart got=%0h/%0h/%0h exp=1/23/0", ifid_valid, ifid_instr, ifid_pc); end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 49) != 0);
            stall = ($urandom_range(0, 3) == 0);
            redirect_valid = ($urandom_range(0, 7) == 0);
            redirect_pc = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 7));
            clk_edge();
            checks++; if (imem_pc !== 8'(m_pc)) begin failures++; $display("FAIL rnd_imem_pc[%0d] got=%0h exp=%0h", i, imem_pc, m_pc); end
            checks++; if (halted !== m_halted) begin failures++; $display("FAIL rnd_halted[%0d] got=%0h exp=%0h", i, halted, m_halted); end
            checks++; if (ifid_valid !== m_valid) begin failures++; $display("FAIL rnd_valid[%0d] got=%0h exp=%0h", i, ifid_valid, m_valid); end
            checks++; if (ifid_instr !== 8'(m_instr)) begin failures++; $display("FAIL rnd_instr[%0d] got=%0h exp=%0h", i, ifid_instr, m_instr); end
            checks++; if (ifid_pc !== 8'(m_ifpc)) begin failures++; $display("FAIL rnd_ifpc[%0d] got=%0h exp=%0h", i, ifid_pc, m_ifpc); end
        end
        rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0;
    endtask

    initial begin
        for (int a = 0; a < 256; a++) mem[a] = 8'($urandom_range(0, 255));
        mem[0] = 8'h23; mem[1] = 8'h61; mem[2] = 8'h1A;
        mem[3] = 8'hC1; mem[4] = 8'h5B; mem[5] = 8'h3C;
        m_pc = 0; m_ifpc = 0; m_instr = 0; m_valid = 0; m_halted = 0;

        test_reset();
        test_sequence();
        test_stall();
        test_redirect_stall();
        test_redirect_halted();
        test_reset_mid();
        test_random();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the 8-bit five-stage pipeline. It owns the program counter, drives the address into the combinational instruction memory, and captures the returned instruction into the IF/ID pipeline register. It also handles stalls from the hazard unit, redirects from later stages, end-of-program halt and, optionally, early resolution of `j` in fetch. It sits directly upstream of the instruction memory address port and directly feeds the decode stage.

## Interface
- `PC_W`, 8, PC and address width
- `INSTR_W`, 8, instruction width
- `FETCH_LIMIT`, 8, first PC that is not fetched; reaching it halts fetch
- `clk` input 1: clock, rising edge
- `rst` input 1: reset, synchronous, active-low
- `stall_i` input 1: hazard unit holds PC and IF/ID
- `redirect_valid_i` input 1: downstream redirect/flush request
- `redirect_pc_i` input PC_W: redirect target
- `imem_pc_o` output PC_W: address to instruction memory
- `imem_instr_i` input INSTR_W: combinational read data for `imem_pc_o`
- `ifid_valid_o` output 1: IF/ID holds a real instruction
- `ifid_instr_o` output INSTR_W: IF/ID instruction
- `ifid_pc_o` output PC_W: PC of the IF/ID instruction
- `halted_o` output 1: fetch stopped at `FETCH_LIMIT`

## Operation
- Registers:
  - `pc`
  - `halted`
  - IF/ID register: valid, instr, pc
- `imem_pc_o` = `pc` combinationally. Instruction memory read is combinational, so `imem_instr_i` is sampled on the same edge.
- The next-state priority is evaluated every edge while `rst`=1. The first matching case applies:
  1. `redirect_valid_i`: `pc`←`redirect_pc_i`; IF/ID valid←0; `halted`←(`redirect_pc_i` ≥ `FETCH_LIMIT`). This overrides `stall_i`.
  2. `stall_i`: `pc`, IF/ID and `halted` all hold.
  3. `halted`: `pc` holds; IF/ID valid←0.
  4. Normal fetch: IF/ID←{1, `imem_instr_i`, `pc`}; `pc`←next_pc; `halted`←(next_pc ≥ `FETCH_LIMIT`).
- next_pc:
  - Default is `pc`+1, modulo 2^PC_W, so 8'hFF wraps to 8'h00.
  - With predecode enabled (see Configuration), a `j` uses the jump target instead.
- Arithmetic:
  - Jump target = `pc` + 1 + sign-extended imm[5:0], truncated to PC_W.
  - Negative offsets are legal.
  - A target of `pc`+1+(-1) = `pc` is a self-loop and is legal.
- Encoding: opcode = instr[7:6]. `j` = 2'b11 with imm[5:0]. The other opcodes pass through untouched.
- The halt check is unsigned. Out-of-range memory words are never captured with valid=1.

## Timing
- Reset (`rst`=0 at an edge):
  - `pc`=0, `halted`=0.
  - `ifid_valid_o`=0, `ifid_instr_o`=0, `ifid_pc_o`=0.
  - Memory contents are loaded during reset; nothing is captured while `rst`=0.
- Latency: the instruction at `pc` appears in IF/ID one edge after it is presented. The first valid IF/ID is the first edge with `rst`=1, carrying mem[0] and pc 0.
- Throughput: one instruction per cycle absent stall, redirect or halt.
- Redirect: the instruction currently fetched is discarded (one bubble). The target is presented on `imem_pc_o` in the next cycle.
- Stall asserted for N cycles: all outputs are frozen for N cycles and nothing is dropped.
- Reset mid-operation: the synchronous reset wins over everything. All state returns to the reset values at that edge.
- `halted_o` is registered and rises on the same edge that moves `pc` to `FETCH_LIMIT`.

## Configuration
- `FETCH_JUMP_PREDECODE_EN` defined:
  - A `j` at `pc` sets next_pc to the jump target in the normal-fetch case.
  - The `j` itself still enters IF/ID with valid=1, so downstream can retire it.
  - No bubble is inserted.
- Undefined:
  - `j` is fetched sequentially (next_pc = `pc`+1).
  - Downstream resolves the jump via `redirect_valid_i`, costing redirect bubbles.

## Structure
- Shared package `riscv8_pkg`:
  - `PC_W`, `INSTR_W`
  - opcode constants, with `OPC_J`=2'b11
  - `ifid_t` struct {valid, instr, pc}
- One sub-module, `jump_predecode`:
  - Combinational.
  - Inputs: instr, pc.
  - Outputs: is_jump, target.
  - Instantiated only under `FETCH_JUMP_PREDECODE_EN`.

## Test plan
All scenarios run against this memory image: 23,61,1A,C1,5B,3C.
- Reset then release with `FETCH_LIMIT`=6 and predecode on → IF/ID pc sequence 0,1,2,3,5 with instr 23,61,1A,C1,3C; `halted_o`=1 after pc 5; valid stays 0 thereafter.
- Same stimulus with predecode off → pc sequence 0..5; instr 5B at pc 4 is valid; halt after pc 5.
- `stall_i` high for 3 cycles while IF/ID holds pc 1 → outputs frozen at 61/pc 1; pc 2 follows after release.
- `redirect_valid_i` with target 4, asserted together with `stall_i`, while IF/ID holds pc 2 → next IF/ID valid=0; the edge after that gives 5B/pc 4.
- Redirect to 8'h00 while halted → `halted_o`←0; fetch restarts at 23/pc 0.
- `rst`=0 for one edge mid-stream at pc 3 → all outputs 0 at that edge; 23/pc 0 follows the first edge with `rst`=1.
